// File: rtl/dmux_stream_nway.sv
// Registered N-way packet demultiplexer for valid/ready streams.
// The destination is locked on the first beat and comes from sel or a round-robin pointer.
module dmux_stream_nway #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic [CHANNELS-1:0] out_valid,
  input  logic [CHANNELS-1:0] out_ready,
  output logic [SEL_W-1:0]    cur_chan,
  output logic                drop
);

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  localparam logic [SEL_W:0]   CHAN_LIMIT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CHAN  = SEL_W'(CHANNELS-1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] lock_chan, lock_chan_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_nxt, rr_inc;
  logic [SEL_W-1:0] target, load_chan, dest;
  logic             lock_rr, lock_rr_nxt;
  logic             out_vld, accept, load, discard, sel_bad;

  assign sel_bad  = !mode && ({1'b0, sel} >= CHAN_LIMIT);
  assign target   = mode ? rr_ptr : sel;
  assign rr_inc   = (rr_ptr == LAST_CHAN) ? '0 : rr_ptr + 1'b1;
  // Ready passes straight through from the held beat's consumer, so a
  // streaming consumer sees one beat per cycle.
  assign in_ready = rst_n && ((state == DROP) || !out_vld || out_ready[dest]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt     = state;
    lock_chan_nxt = lock_chan;
    lock_rr_nxt   = lock_rr;
    rr_ptr_nxt    = rr_ptr;
    load          = 1'b0;
    discard       = 1'b0;
    load_chan     = lock_chan;
    if (accept) begin
      case (state)
        IDLE: begin
          if (sel_bad) begin
            discard = 1'b1;
            if (!in_last) state_nxt = DROP;
          end else begin
            load      = 1'b1;
            load_chan = target;
            if (!in_last) begin
              state_nxt     = ROUTE;
              lock_chan_nxt = target;
              lock_rr_nxt   = mode;
            end else if (mode) begin
              rr_ptr_nxt = rr_inc;
            end
          end
        end
        ROUTE: begin
          load = 1'b1;
          if (in_last) begin
            state_nxt = IDLE;
            if (lock_rr) rr_ptr_nxt = rr_inc;
          end
        end
        DROP: begin
          discard = 1'b1;
          if (in_last) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lock_chan <= '0;
      lock_rr   <= 1'b0;
      rr_ptr    <= '0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_chan <= lock_chan_nxt;
      lock_rr   <= lock_rr_nxt;
      rr_ptr    <= rr_ptr_nxt;
      drop      <= discard;
    end
  end

  // Single output stage: a new beat replaces the held one only when it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      dest     <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (load) begin
      out_vld  <= 1'b1;
      dest     <= load_chan;
      out_data <= in_data;
      out_last <= in_last;
    end else if (out_vld && out_ready[dest]) begin
      out_vld <= 1'b0;
    end
  end

  assign out_valid = out_vld ? (CHANNELS'(1) << dest) : '0;
  assign cur_chan  = (state == ROUTE) ? lock_chan : target;

endmodule

// File: tb/tb_dmux_stream_nway.sv
// Self-checking bench: an 8-channel and a 6-channel demux share one input stream
// and are compared every cycle against a packet-level reference model.
module tb_dmux_stream_nway;

  localparam int W  = 16;
  localparam int SW = 3;
  localparam int C0 = 8;
  localparam int C1 = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [C0-1:0] ordy0 = '1;
  logic [C1-1:0] ordy1 = '1;

  logic          in_ready0, in_ready1, out_last0, out_last1, drop0, drop1;
  logic [W-1:0]  out_data0, out_data1;
  logic [C0-1:0] out_valid0;
  logic [C1-1:0] out_valid1;
  logic [SW-1:0] cur_chan0, cur_chan1;

  int total = 0;
  int passed = 0;
  int dropCount1 = 0;

  dmux_stream_nway #(.WIDTH(W), .CHANNELS(C0), .SEL_W(SW)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready0),
    .out_data(out_data0), .out_last(out_last0), .out_valid(out_valid0),
    .out_ready(ordy0), .cur_chan(cur_chan0), .drop(drop0));

  dmux_stream_nway #(.WIDTH(W), .CHANNELS(C1), .SEL_W(SW)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready1),
    .out_data(out_data1), .out_last(out_last1), .out_valid(out_valid1),
    .out_ready(ordy1), .cur_chan(cur_chan1), .drop(drop1));

  always #5 clk = ~clk;

  // Reference model: packet phase 0=between packets, 1=routing, 2=discarding.
  int         chans [2] = '{C0, C1};
  int         m_state [2] = '{0, 0};
  int         m_lock [2] = '{0, 0};
  int         m_rr [2] = '{0, 0};
  int         m_hd [2] = '{0, 0};
  bit         m_hv [2] = '{0, 0};
  bit         m_hlast [2] = '{0, 0};
  bit         m_drop [2] = '{0, 0};
  bit         m_lockrr [2] = '{0, 0};
  logic [W-1:0] m_hdata [2];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    else
      passed++;
  endtask

  function automatic logic [7:0] rdyVec(input int i);
    return (i == 0) ? ordy0 : {2'b00, ordy1};
  endfunction

  function automatic bit expReady(input int i);
    logic [7:0] r;
    r = rdyVec(i);
    return rst_n && (m_state[i] == 2 || !m_hv[i] || r[m_hd[i]]);
  endfunction

  task automatic modelStep(input int i);
    int c, ld;
    bit acc, load, drn;
    logic [7:0] r;
    c    = chans[i];
    r    = rdyVec(i);
    acc  = in_valid && expReady(i);
    drn  = m_hv[i] && r[m_hd[i]];
    load = 0;
    ld   = 0;
    m_drop[i] = 0;
    if (acc) begin
      if (m_state[i] == 0) begin
        if (!mode && int'(sel) >= c) begin
          m_drop[i] = 1;
          if (!in_last) m_state[i] = 2;
        end else begin
          load = 1;
          ld = mode ? m_rr[i] : int'(sel);
          if (!in_last) begin
            m_state[i] = 1;
            m_lock[i] = ld;
            m_lockrr[i] = mode;
          end else if (mode) begin
            m_rr[i] = (m_rr[i] + 1) % c;
          end
        end
      end else if (m_state[i] == 1) begin
        load = 1;
        ld = m_lock[i];
        if (in_last) begin
          m_state[i] = 0;
          if (m_lockrr[i]) m_rr[i] = (m_rr[i] + 1) % c;
        end
      end else begin
        m_drop[i] = 1;
        if (in_last) m_state[i] = 0;
      end
    end
    if (load) begin
      m_hv[i] = 1;
      m_hd[i] = ld;
      m_hdata[i] = in_data;
      m_hlast[i] = in_last;
    end else if (drn) begin
      m_hv[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_state[i] = 0; m_rr[i] = 0; m_hv[i] = 0; m_drop[i] = 0; m_lock[i] = 0; m_hd[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) modelStep(i);
    end
  end

  task automatic compareInst(input int i, input logic rdy, input logic [7:0] vld, input logic [W-1:0] data,
                             input logic last, input logic [SW-1:0] cur, input logic drp);
    logic [7:0] ev;
    int ec;
    ev = m_hv[i] ? (8'd1 << m_hd[i]) : 8'd0;
    ec = (m_state[i] == 1) ? m_lock[i] : (mode ? m_rr[i] : int'(sel));
    checkOutput($sformatf("inst%0d in_ready", i), 32'(rdy), 32'(expReady(i)));
    checkOutput($sformatf("inst%0d out_valid", i), 32'(vld), 32'(ev));
    if (m_hv[i]) begin
      checkOutput($sformatf("inst%0d out_data", i), 32'(data), 32'(m_hdata[i]));
      checkOutput($sformatf("inst%0d out_last", i), 32'(last), 32'(m_hlast[i]));
    end
    checkOutput($sformatf("inst%0d cur_chan", i), 32'(cur), 32'(ec));
    checkOutput($sformatf("inst%0d drop", i), 32'(drp), 32'(m_drop[i]));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset in_ready0", 32'(in_ready0), 32'd0);
      checkOutput("reset out_valid0", 32'(out_valid0), 32'd0);
      checkOutput("reset in_ready1", 32'(in_ready1), 32'd0);
      checkOutput("reset out_valid1", 32'(out_valid1), 32'd0);
    end else begin
      compareInst(0, in_ready0, out_valid0, out_data0, out_last0, cur_chan0, drop0);
      compareInst(1, in_ready1, {2'b00, out_valid1}, out_data1, out_last1, cur_chan1, drop1);
      if (drop1) dropCount1++;
    end
  end

  // Holds a beat on the input until the 8-channel instance takes it.
  task automatic applyStimulus(input logic [W-1:0] d, input logic l);
    bit got;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = in_valid && in_ready0;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) checkOutput("accept timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("lit reset in_ready0", 32'(in_ready0), 32'd0);
    checkOutput("lit reset out_valid0", 32'(out_valid0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("lit reset out_data0", 32'(out_data0), 32'd0);
    checkOutput("lit reset out_last0", 32'(out_last0), 32'd0);
    checkOutput("lit reset cur_chan0", 32'(cur_chan0), 32'd0);
    checkOutput("lit idle in_ready0", 32'(in_ready0), 32'd1);

    // Single-beat packets to every channel by explicit select.
    for (int s = 0; s < 8; s++) begin
      sel = SW'(s);
      applyStimulus(16'h00A0 + 16'(s), 1'b1);
      checkOutput("lit single out_valid0", 32'(out_valid0), 32'(1) << s);
      checkOutput("lit single out_data0", 32'(out_data0), 32'h00A0 + 32'(s));
      checkOutput("lit single out_last0", 32'(out_last0), 32'd1);
    end

    // sel changes mid-packet are ignored once the channel is locked.
    sel = 3'd5;
    applyStimulus(16'h0B01, 1'b0);
    checkOutput("lit lock first", 32'(out_valid0), 32'h20);
    checkOutput("lit lock first last", 32'(out_last0), 32'd0);
    sel = 3'd2;
    applyStimulus(16'h0B02, 1'b0);
    checkOutput("lit lock mid", 32'(out_valid0), 32'h20);
    applyStimulus(16'h0B03, 1'b0);
    checkOutput("lit lock mid last", 32'(out_last0), 32'd0);
    applyStimulus(16'h0B04, 1'b1);
    checkOutput("lit lock end", 32'(out_valid0), 32'h20);
    checkOutput("lit lock end last", 32'(out_last0), 32'd1);
    applyStimulus(16'h0B05, 1'b1);
    checkOutput("lit next pkt chan", 32'(out_valid0), 32'h04);

    // Backpressure on the locked channel; another channel's ready is irrelevant.
    ordy0 = 8'hDF;
    sel = 3'd5;
    applyStimulus(16'h0C01, 1'b0);
    in_valid = 1'b1; in_data = 16'h0C02; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("lit stall in_ready0", 32'(in_ready0), 32'd0);
      checkOutput("lit stall out_data0", 32'(out_data0), 32'h0C01);
      checkOutput("lit stall out_valid0", 32'(out_valid0), 32'h20);
      @(posedge clk);
      #1;
    end
    ordy0 = '1;
    applyStimulus(16'h0C02, 1'b0);
    checkOutput("lit resume data", 32'(out_data0), 32'h0C02);
    applyStimulus(16'h0C03, 1'b1);
    checkOutput("lit resume last", 32'(out_last0), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // sel=7 is out of range for the 6-channel instance: whole packet discarded.
    sel = 3'd7;
    begin
      int c0;
      c0 = dropCount1;
      applyStimulus(16'h0D01, 1'b0);
      checkOutput("lit drop ch7 inst0", 32'(out_valid0), 32'h80);
      applyStimulus(16'h0D02, 1'b0);
      applyStimulus(16'h0D03, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("lit drop count", 32'(dropCount1 - c0), 32'd3);
      checkOutput("lit drop no valid", 32'(out_valid1), 32'd0);
    end
    sel = 3'd3;
    applyStimulus(16'h0D10, 1'b1);
    checkOutput("lit after drop", 32'(out_valid1), 32'h08);

    // Round-robin: nine 2-beat packets walk through the channels.
    mode = 1'b1;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(16'h1000 + 16'(2 * k), 1'b0);
      checkOutput("lit rr dest", 32'(out_valid0), 32'(1) << (k % 8));
      applyStimulus(16'h1001 + 16'(2 * k), 1'b1);
      checkOutput("lit rr cur_chan", 32'(cur_chan0), 32'((k + 1) % 8));
    end

    // Reset in the middle of a routed packet.
    mode = 1'b0;
    sel = 3'd4;
    applyStimulus(16'h0E01, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("lit midreset out_valid0", 32'(out_valid0), 32'd0);
    checkOutput("lit midreset in_ready0", 32'(in_ready0), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    mode = 1'b1;
    #1;
    checkOutput("lit midreset rr", 32'(cur_chan0), 32'd0);
    mode = 1'b0;
    sel = 3'd1;
    applyStimulus(16'h0E02, 1'b1);
    checkOutput("lit midreset route", 32'(out_valid0), 32'h02);
    checkOutput("lit midreset data", 32'(out_data0), 32'h0E02);

    // Randomized traffic with backpressure, mode flips and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 400) == 0) rst_n = 1'b0;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
      in_last  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
      sel   = SW'($urandom);
      ordy0 = C0'($urandom | $urandom);
      ordy1 = C1'($urandom | $urandom);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
